// File: rtl/program_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words,
// writes them to instruction memory, then releases the processor from reset.
//
// state | meaning
// LOAD  | accepting image bytes into the word buffer
// WRITE | one-cycle memory write of the assembled word
// DONE  | image loaded, processor running; waits for reload
// ERR   | truncated or oversized image; exits only on rst
module program_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_rst,
    output logic              cpu_start,
    output logic [ADDR_W:0]   word_count,
    output logic              error
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        last_seen;

    // word_count doubles as the write index, so it can never wrap past MAX_CNT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            last_seen  <= 1'b0;
            word_count <= '0;
            mem_addr   <= '0;
            mem_data   <= 32'd0;
            mem_wren   <= 1'b0;
            in_ready   <= 1'b0;
            cpu_rst    <= 1'b1;
            cpu_start  <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            case (state)
                S_LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (word_count == MAX_CNT || (in_last && byte_idx != 2'd3)) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else if (byte_idx == 2'd3) begin
                            state     <= S_WRITE;
                            in_ready  <= 1'b0;
                            mem_wren  <= 1'b1;
                            mem_addr  <= word_count[ADDR_W-1:0];
                            mem_data  <= {in_data, word_buf};
                            last_seen <= in_last;
                        end else begin
                            case (byte_idx)
                                2'd0:    word_buf[7:0]   <= in_data;
                                2'd1:    word_buf[15:8]  <= in_data;
                                default: word_buf[23:16] <= in_data;
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + CNT_ONE;
                    byte_idx   <= 2'd0;
                    if (last_seen) begin
                        state     <= S_DONE;
                        cpu_rst   <= 1'b0;
                        cpu_start <= 1'b1;
                    end else begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (reload) begin
                        state      <= S_LOAD;
                        word_count <= '0;
                        byte_idx   <= 2'd0;
                        last_seen  <= 1'b0;
                        in_ready   <= 1'b1;
                        cpu_rst    <= 1'b1;
                        cpu_start  <= 1'b0;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    cpu_rst   <= 1'b1;
                    cpu_start <= 1'b0;
                    error     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the word-address width of the target instruction memory (2^ADDR_W words).
REQ-002 The module SHALL have parameter MAX_WORDS, default 2^ADDR_W, giving the image-size limit in words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  byte-stream source has a byte.
REQ-006 in_data  input  8  image byte, little-endian within each 32-bit word.
REQ-007 in_last  input  1  qualifies the current byte as the final byte of the image.
REQ-008 in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-009 reload  input  1  single-cycle request to restart loading; honoured only in DONE.
REQ-010 mem_addr  output  ADDR_W  instruction-memory write word address.
REQ-011 mem_data  output  32  assembled instruction word.
REQ-012 mem_wren  output  1  instruction-memory write strobe, one cycle per word.
REQ-013 cpu_rst  output  1  holds the processor in reset while high.
REQ-014 cpu_start  output  1  instruction-fetch enable to the processor.
REQ-015 word_count  output  ADDR_W+1  number of words written since the last load start.
REQ-016 error  output  1  sticky load-failure flag.

Function
REQ-017 The FSM SHALL have states LOAD, WRITE, DONE and ERR, with all outputs registered.
REQ-018 In LOAD, in_ready=1, and each accepted byte SHALL be placed into byte lane byte_idx (0..3) of the word buffer, after which byte_idx increments.
REQ-019 On acceptance of a byte with byte_idx=3, the FSM SHALL enter WRITE on the next cycle, with mem_wren=1, mem_data equal to the full word and mem_addr equal to the current word index; in_ready=0 in WRITE.
REQ-020 WRITE SHALL last exactly one cycle, after which the word index and word_count increment and byte_idx clears to 0.
REQ-021 From WRITE, the FSM SHALL go to DONE if in_last accompanied the fourth byte, and otherwise return to LOAD.
REQ-022 Latency from the fourth-byte handshake edge to the mem_wren-high cycle SHALL be exactly 1 cycle, giving a maximum throughput of 4 bytes per 5 cycles.
REQ-023 An accepted byte with in_last=1 and byte_idx≠3 SHALL send the FSM to ERR; no partial word is written.
REQ-024 A byte accepted while word_count=MAX_WORDS SHALL send the FSM to ERR; the word index never wraps to 0.
REQ-025 If in_valid is low in LOAD, the FSM SHALL hold its state with no counter change.
REQ-026 In DONE: in_ready=0, cpu_rst=0, cpu_start=1, and mem_wren=0.
REQ-027 In DONE, reload=1 SHALL return the FSM to LOAD with the word index, byte_idx and word_count cleared, and cpu_rst=1 and cpu_start=0 from the next cycle.
REQ-028 reload SHALL be ignored in LOAD, WRITE and ERR.
REQ-029 In ERR: error=1, in_ready=0, cpu_rst=1, cpu_start=0, and mem_wren=0; the FSM leaves ERR only on rst.
REQ-030 In all states other than DONE: cpu_rst=1 and cpu_start=0.
REQ-031 in_data and in_last SHALL be ignored whenever in_ready=0.
REQ-032 A zero-length image (no bytes) SHALL keep the FSM in LOAD indefinitely.

Reset
REQ-033 While rst=1, the module SHALL immediately force the following, independent of clk: state=LOAD, byte_idx=0, word index=0, word_count=0, mem_addr=0, mem_data=0, mem_wren=0, in_ready=0, cpu_rst=1, cpu_start=0, error=0.
REQ-034 in_ready SHALL rise on the first rising edge after rst falls.
REQ-035 rst asserted during WRITE SHALL suppress that write.

Verification
REQ-036 Scenario: bytes 13,00,50,00 then 93,02,A0,00 (in_last on the final byte) -> writes 0x00500013 @0, then 0x00A00293 @1; word_count=2; DONE with cpu_rst=0 and cpu_start=1.
REQ-037 Scenario: six bytes with in_last on the 6th -> one write @0, then ERR with error=1 and cpu_rst=1; no second write occurs.
REQ-038 Scenario: with MAX_WORDS=4, send 4 full words without in_last, then 1 more byte -> ERR; mem_addr never exceeds 3.
REQ-039 Scenario: in_valid toggled randomly during a 3-word image -> identical memory contents; in_ready=0 exactly in each WRITE cycle.
REQ-040 Scenario: in DONE, pulse reload and load 1 word AABBCCDD -> write 0xDDCCBBAA @0; word_count=1; cpu_rst high through the load, low after it.
REQ-041 Scenario: assert rst mid-word (after 2 bytes) -> outputs immediately take REQ-033 values; the next 4 bytes write @0.
